memory_stage: RTL
=================

# memory_stage

Pipeline stage directly downstream of the execute stage. It registers the execute-stage outputs and waits for the data SRAM read response on loads. It aligns and extends the returned word for LB/LBU/LH/LHU/LW/LWL/LWR and presents the result to write-back, with a forwarding port for decode. Non-load instructions pass their execute value through unchanged.

## Interface
Parameters:
- OPW, 39, width of the control op bus (same bit map as the execute stage, cpu.h macros).

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- stall  in  1  global hold from downstream/hazard logic; the MEM register holds its contents.
- excp  in  1  exception flush; the instruction entering from EXE this edge is replaced by a bubble.
- exe_out_en  in  1  EXE holds a valid instruction.
- exe_out_op  in  OPW  EXE control op.
- exe_dest  in  5  destination reg (already 0 on overflow or bad read address).
- exe_value  in  32  ALU/HI/LO/CP0 result; the effective address for memory ops.
- exe_rt_value  in  32  old rt value, merged by LWL/LWR.
- exe_rbadaddr  in  1  load address misaligned; no SRAM data will be awaited.
- data_sram_rdata  in  32  read data, valid when data_sram_rvalid=1.
- data_sram_rvalid  in  1  one-cycle read-response strobe.
- exe_pc, exe_inst  in  32 each  debug passthrough.
- mem_out_en  out  1  MEM result valid for WB this cycle.
- mem_out_op  out  OPW  registered op.
- mem_dest  out  5  registered dest.
- mem_value  out  32  final result.
- mem_busy  out  1  waiting for load data; upstream must hold.
- mem_fwd_ok  out  1  mem_value usable for bypass (=0 while busy).
- mem_pc, mem_inst  out  32 each  debug passthrough.

## Operation
- Internal registers: op_r, dest_r, value_r, rt_r, two_r = exe_value[1:0], valid_r, rdata_q, state.
- adv = ~stall & ~mem_busy. On an adv edge, load from EXE. If excp=1 or exe_out_en=0, load a bubble instead: op_r=1 (EMPTY only), dest_r=0, valid_r=0.
- is_load = any of LB, LBU, LH, LHU, LW, LWL, LWR in the incoming op, with exe_rbadaddr=0 and a valid non-flushed instruction.
- FSM states:
  - IDLE→WAIT on adv with is_load.
  - IDLE→IDLE on adv otherwise.
  - WAIT→HOLD on data_sram_rvalid, capturing rdata_q.
  - HOLD→WAIT or IDLE on adv, using the same rule as IDLE.
  - WAIT with no rvalid: stay. stall has no effect on WAIT→HOLD.
- data_sram_rvalid outside WAIT is ignored.
- mem_busy = (state==WAIT). mem_out_en = valid_r & ~mem_busy. mem_fwd_ok = mem_out_en.
- mem_value = value_r for non-loads; otherwise align(rdata_q), little-endian, with two = two_r:
  - LB/LBU: byte two, sign-/zero-extended.
  - LH/LHU: half two[1], sign-/zero-extended.
  - LW: rdata_q.
  - LWL, two = 0/1/2/3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
  - LWR, two = 0/1/2/3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
- A load with exe_rbadaddr=1 travels as a non-load: mem_value = value_r (the bad vaddr), dest already 0.

## Timing
- Reset (async, immediate):
  - state=IDLE, op_r=0, dest_r=0, value_r=0, rt_r=0, rdata_q=0, valid_r=0.
  - All outputs 0: mem_out_en=0, mem_busy=0, mem_fwd_ok=0, mem_pc=0, mem_inst=0.
- Reset deasserted mid-load: the pending response is lost. After release state is IDLE and any rvalid is ignored.
- Non-load latency: 1 cycle EXE→MEM-valid.
- Load latency: enters at edge N. rvalid in cycle N+k (k≥0) gives HOLD and mem_out_en=1 in cycle N+k+1. The earliest result is one cycle after entry; mem_busy is high for cycles N..N+k.
- rvalid and stall high together in WAIT: data is captured, then HOLD persists until stall drops.
- excp during WAIT: the MEM load is older and completes normally. Only the incoming instruction is bubbled.

## Test plan
- ADDU result 0x00001234, dest 5, no stall -> next cycle mem_out_en=1, mem_value=0x00001234, mem_dest=5, mem_busy=0.
- LB addr 0x...03, rvalid same cycle with rdata 0x80FF_1122 -> cycle 1 mem_busy=1, cycle 2 mem_value=0xFFFFFF80; repeat with LBU -> 0x00000080.
- LWL two=1, rt=0xAABBCCDD, rdata 0x11223344 -> 0x3344CCDD. LWR two=2, same values -> 0xAABB1122.
- LH with rvalid delayed 3 cycles while EXE holds a new ADD -> mem_busy high 4 cycles, ADD not accepted, ADD valid one cycle after load result.
- LW with exe_rbadaddr=1, value 0x00000102 -> state stays IDLE, mem_value=0x00000102, mem_dest=0, no busy. A spurious rvalid has no effect.
- Assert excp with an incoming LW while an older LH is in WAIT -> LH completes. The next MEM entry is a bubble (mem_out_en=0, op=1). Pulse resetn low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: pipeline register between execute and write-back.
// Captures the EXE result. On loads it waits for the data SRAM read
// response, then aligns and extends the returned word. Other instructions
// pass their EXE value straight through.
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   stall, excp             global hold, flush of the incoming instruction
//   exe_*                   instruction presented by the execute stage
//   data_sram_rdata/rvalid  load response (one-cycle strobe)
//   mem_out_en/op/dest/value result towards write-back
//   mem_busy                load outstanding, upstream must hold
//   mem_fwd_ok              mem_value may be bypassed to decode
//   mem_pc, mem_inst        debug passthrough
//
// FSM states:
//   state  | meaning
//   S_IDLE | no load outstanding; MEM holds a non-load or a bubble
//   S_WAIT | load registered, waiting for data_sram_rvalid
//   S_HOLD | load data captured in rdata_q, result presented
module memory_stage #(
  parameter int OPW     = 39,
  // Load bit positions in the op bus; bit 0 is EMPTY.
  parameter int OP_LB   = 21,
  parameter int OP_LBU  = 22,
  parameter int OP_LH   = 23,
  parameter int OP_LHU  = 24,
  parameter int OP_LW   = 25,
  parameter int OP_LWL  = 26,
  parameter int OP_LWR  = 27
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           stall,
  input  logic           excp,
  input  logic           exe_out_en,
  input  logic [OPW-1:0] exe_out_op,
  input  logic [4:0]     exe_dest,
  input  logic [31:0]    exe_value,
  input  logic [31:0]    exe_rt_value,
  input  logic           exe_rbadaddr,
  input  logic [31:0]    data_sram_rdata,
  input  logic           data_sram_rvalid,
  input  logic [31:0]    exe_pc,
  input  logic [31:0]    exe_inst,
  output logic           mem_out_en,
  output logic [OPW-1:0] mem_out_op,
  output logic [4:0]     mem_dest,
  output logic [31:0]    mem_value,
  output logic           mem_busy,
  output logic           mem_fwd_ok,
  output logic [31:0]    mem_pc,
  output logic [31:0]    mem_inst
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t         state, state_nxt;
  logic [OPW-1:0] op_r;
  logic [4:0]     dest_r;
  logic [31:0]    value_r;
  logic [31:0]    rt_r;
  logic [1:0]     two_r;
  logic           valid_r;
  logic [31:0]    rdata_q;
  logic [31:0]    pc_r;
  logic [31:0]    inst_r;

  logic           adv;
  logic           flush_in;
  logic           is_load;
  logic           use_align;
  logic [31:0]    align_val;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;

  assign adv      = ~stall & ~mem_busy;
  assign flush_in = excp | ~exe_out_en;
  // A misaligned load never issues a read, so it is treated as a non-load.
  assign is_load  = ~flush_in & ~exe_rbadaddr &
                    (exe_out_op[OP_LB]  | exe_out_op[OP_LBU] |
                     exe_out_op[OP_LH]  | exe_out_op[OP_LHU] |
                     exe_out_op[OP_LW]  | exe_out_op[OP_LWL] |
                     exe_out_op[OP_LWR]);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HOLD: begin
        if (adv) state_nxt = is_load ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        // stall does not block the response capture
        if (data_sram_rvalid) state_nxt = S_HOLD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    mem_busy  = (state == S_WAIT);
    // Only a real load leaves IDLE, so any non-IDLE state selects the aligner.
    use_align = (state != S_IDLE);
  end

  // Pipeline register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_r    <= '0;
      dest_r  <= '0;
      value_r <= '0;
      rt_r    <= '0;
      two_r   <= '0;
      valid_r <= 1'b0;
      pc_r    <= '0;
      inst_r  <= '0;
    end else if (adv) begin
      value_r <= exe_value;
      rt_r    <= exe_rt_value;
      two_r   <= exe_value[1:0];
      pc_r    <= exe_pc;
      inst_r  <= exe_inst;
      if (flush_in) begin
        op_r    <= {{(OPW-1){1'b0}}, 1'b1};
        dest_r  <= '0;
        valid_r <= 1'b0;
      end else begin
        op_r    <= exe_out_op;
        dest_r  <= exe_dest;
        valid_r <= 1'b1;
      end
    end
  end

  // Load response capture; responses outside WAIT are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                  rdata_q <= '0;
    else if (state == S_WAIT && data_sram_rvalid) rdata_q <= data_sram_rdata;
  end

  // Little-endian alignment and LWL/LWR merge
  always_comb begin
    byte_sel  = rdata_q[{two_r, 3'b000} +: 8];
    half_sel  = rdata_q[{two_r[1], 4'b0000} +: 16];
    align_val = rdata_q;
    if (op_r[OP_LB])       align_val = {{24{byte_sel[7]}}, byte_sel};
    else if (op_r[OP_LBU]) align_val = {24'd0, byte_sel};
    else if (op_r[OP_LH])  align_val = {{16{half_sel[15]}}, half_sel};
    else if (op_r[OP_LHU]) align_val = {16'd0, half_sel};
    else if (op_r[OP_LWL]) begin
      case (two_r)
        2'd0:    align_val = {rdata_q[7:0],  rt_r[23:0]};
        2'd1:    align_val = {rdata_q[15:0], rt_r[15:0]};
        2'd2:    align_val = {rdata_q[23:0], rt_r[7:0]};
        default: align_val = rdata_q;
      endcase
    end else if (op_r[OP_LWR]) begin
      case (two_r)
        2'd0:    align_val = rdata_q;
        2'd1:    align_val = {rt_r[31:24], rdata_q[31:8]};
        2'd2:    align_val = {rt_r[31:16], rdata_q[31:16]};
        default: align_val = {rt_r[31:8],  rdata_q[31:24]};
      endcase
    end
  end

  assign mem_out_en = valid_r & ~mem_busy;
  assign mem_fwd_ok = mem_out_en;
  assign mem_out_op = op_r;
  assign mem_dest   = dest_r;
  assign mem_value  = use_align ? align_val : value_r;
  assign mem_pc     = pc_r;
  assign mem_inst   = inst_r;

endmodule
